pc_fetch_sequencer: RTL
=======================

# pc_fetch_sequencer

Program-counter and fetch sequencer for the RISC-V core. It consumes the sign-extended immediates produced by the immediate sign-extension stages: the 21-bit J-type offset, the 13-bit B-type offset and the 12-bit I-type offset. From these it computes the next PC for sequential, JAL, taken-branch and JALR flow. It drives a request/ready handshake to instruction memory and exposes the link address for rd write-back.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- imm_ext  input  32  sign-extended offset from the sign-extension stage; sampled in EXEC only.
- rs1_data  input  32  JALR base register value.
- jal  input  1  current instruction is JAL.
- jalr  input  1  current instruction is JALR.
- branch_taken  input  1  current instruction is a branch whose condition evaluated true.
- stall  input  1  hold the current instruction in EXEC.
- imem_ready  input  1  instruction memory has returned data for imem_addr.
- imem_req  output  1  fetch request; high only in FETCH.
- imem_addr  output  32  equals pc.
- pc  output  32  address of the current instruction.
- link_addr  output  32  pc + 4, modulo 2^32.
- instr_valid  output  1  high only in EXEC; the instruction at pc is being executed.
- misalign_err  output  1  sticky target-misalignment flag.

## Operation
- Each state is encoded in 2 bits:
  - IDLE: entered on reset. Always moves to FETCH on the next edge.
  - FETCH: imem_req=1. If imem_ready=1, moves to EXEC; otherwise stays.
  - EXEC: instr_valid=1. If stall=1, stays with pc unchanged. Otherwise pc <= next_pc and the state moves to FETCH, or to TRAP on misalignment.
  - TRAP: misalign_err=1, imem_req=0, instr_valid=0. Stays in TRAP until reset.
- next_pc is selected by priority: jalr > jal > branch_taken > sequential. Multiple asserted controls resolve by this priority and no error is raised.
  - jalr: (rs1_data + imm_ext) & 32'hFFFF_FFFE.
  - jal or branch_taken: pc + imm_ext.
  - sequential: pc + 4.
- All additions are 32-bit and wrap modulo 2^32. Carry-out is discarded.
- Misalignment: if the selected redirect target has bit[1] or bit[0] set (after JALR bit-0 clearing), the block enters TRAP. In that case pc is NOT updated and misalign_err is set. The sequential path cannot misalign because pc is always word-aligned.
- Control inputs, imm_ext and rs1_data are ignored outside EXEC.
- Reset (rst_n=0 at any edge, including mid-FETCH or in TRAP) forces the following on that edge:
  - state to IDLE;
  - pc to RESET_PC;
  - misalign_err to 0.

## Timing
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, link_addr=RESET_PC+4, imem_req=0, instr_valid=0, misalign_err=0.
- Outputs are decoded from the state and pc registers only; there is no combinational path from inputs to outputs.
- First fetch: imem_req rises one cycle after the first edge with rst_n=1.
- Best-case cadence is 2 cycles per instruction (FETCH, EXEC). Each cycle in which imem_ready=0 adds one cycle, and each stall cycle adds one cycle.
- A redirect takes effect at the EXEC→FETCH edge. The very next imem_addr is the target, with no wrong-path fetch.
- misalign_err asserts in the cycle after the offending EXEC edge and stays high until reset.
- imem_ready is ignored outside FETCH.

## Test plan
- **Reset, then imem_ready=1 permanently:**
  - Required imem_addr sequence: 0x0, 0x4, 0x8.
  - instr_valid is high every second cycle.
  - link_addr is 0x4 while pc=0x0.
- **Wait states and stall:**
  - Stimulus: imem_ready low for 3 cycles at pc=0x8, then stall=1 for 2 EXEC cycles.
  - Required: imem_req is held for 4 cycles, EXEC lasts 3 cycles, and pc is then 0xC.
- **Negative JAL and taken branch:**
  - JAL at pc=0x100 with imm_ext=0xFFFF_FFF0 gives next fetch 0xF0.
  - Branch at 0xF0 with imm_ext=0x20 and branch_taken=1 gives 0x110.
- **JALR bit-0 clearing and priority:**
  - Stimulus: rs1_data=0x2001, imm_ext=0x2, jalr=1 and jal=1 asserted together.
  - Required: next pc 0x2002 is misaligned, so misalign_err=1, state is TRAP and pc is held.
  - Repeat with imm_ext=0x3: required next pc is 0x2004.
- **Wrap-around:** pc=0xFFFF_FFFC sequential gives 0x0000_0000 and link_addr=0x0. JAL with imm_ext=0x8 from 0xFFFF_FFFC gives 0x4.
- **Reset mid-operation:**
  - Assert rst_n=0 during FETCH with imem_ready=0: on the next edge imem_req=0 and pc=RESET_PC.
  - Assert rst_n=0 in TRAP: misalign_err clears and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program-counter and fetch sequencer: steps pc through FETCH/EXEC, resolves
// sequential, JAL, branch and JALR targets, and traps on misaligned redirects.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs1_data,
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch_taken,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        instr_valid,
  output logic        misalign_err
);

  localparam int unsigned xlen = 32;
  localparam logic [xlen-1:0] inst_bytes = xlen'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t          state;
  logic [xlen-1:0] jalr_sum;
  logic [xlen-1:0] next_pc;
  logic            redirect;
  logic            misalign;

  // Target select: jalr > jal > branch_taken > sequential.
  always_comb begin
    redirect = 1'b0;
    next_pc  = pc + inst_bytes;
    jalr_sum = rs1_data + imm_ext;
    if (jalr) begin
      redirect = 1'b1;
      next_pc  = {jalr_sum[xlen-1:1], 1'b0};
    end else if (jal || branch_taken) begin
      redirect = 1'b1;
      next_pc  = pc + imm_ext;
    end
    misalign = redirect && (next_pc[1:0] != 2'b00);
  end

  assign imem_addr = pc;

  // State, pc and all status outputs update together so outputs depend on registers only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      link_addr    <= RESET_PC + inst_bytes;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (misalign) begin
              state        <= TRAP;
              misalign_err <= 1'b1;
            end else begin
              state     <= FETCH;
              imem_req  <= 1'b1;
              pc        <= next_pc;
              link_addr <= next_pc + inst_bytes;
            end
          end
        end
        TRAP: begin
          state        <= TRAP;
          imem_req     <= 1'b0;
          instr_valid  <= 1'b0;
          misalign_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
